// File: rtl/ascii_fixed_point_parser_pkg.sv
// Shared configuration for the ASCII fixed-point parser: field widths, ASCII
// byte classes, FSM state encoding and the per-byte classification record.
// No ports; imported by the interface, the classifier and the parser top.
package ascii_fixed_point_parser_pkg;

  localparam int INT_W_DEFAULT       = 17;
  localparam int FRAC_W_DEFAULT      = 14;
  localparam int FRAC_DIGITS_DEFAULT = 4;
  localparam int NUM_W_DEFAULT       = 1 + INT_W_DEFAULT + FRAC_W_DEFAULT;

  // Largest fraction value the ALU format can carry (FRAC_DIGITS nines).
  localparam int FLOAT_NUMBER_MAX_FLOAT_PART = 9999;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_POINT = 8'h2E;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SEMI  = 8'h3B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INT,
    ST_FRAC,
    ST_SKIP,
    ST_PAD,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic       is_digit;
    logic [3:0] digit;
    logic       is_sign;
    logic       is_neg;
    logic       is_point;
    logic       is_term;
  } char_class_t;

endpackage

// File: rtl/ascii_fixed_point_parser_if.sv
// Byte-stream input and fixed-point result output of the parser, both valid/ready.
// slave: parser side (takes bytes, drives results); master: producer/consumer side.
// Signals: char_valid/char_data/char_ready, num_valid/num_data/num_error/num_ready.
interface ascii_fixed_point_parser_if
  import ascii_fixed_point_parser_pkg::*;
#(
  parameter int NUM_W = NUM_W_DEFAULT
);
  logic             char_valid;
  logic [7:0]       char_data;
  logic             char_ready;
  logic             num_valid;
  logic [NUM_W-1:0] num_data;
  logic             num_error;
  logic             num_ready;

  modport master (
    output char_valid, char_data, num_ready,
    input  char_ready, num_valid, num_data, num_error
  );

  modport slave (
    input  char_valid, char_data, num_ready,
    output char_ready, num_valid, num_data, num_error
  );
endinterface

// File: rtl/ascii_fixed_point_parser_classify.sv
// Purpose: classifies one ASCII byte (digit / sign / point / terminator).
// Latency: purely combinational. Backpressure: none, no state.
// Ports: char_data in (8), cls out (char_class_t); illegal = no class bit set.
module ascii_char_classify
  import ascii_fixed_point_parser_pkg::*;
(
  input  logic [7:0]  char_data,
  output char_class_t cls
);
  always_comb begin
    cls          = '0;
    cls.is_digit = (char_data >= ASCII_0) && (char_data <= ASCII_9);
    cls.digit    = char_data[3:0];
    cls.is_neg   = (char_data == ASCII_MINUS);
    cls.is_sign  = (char_data == ASCII_PLUS) || cls.is_neg;
    cls.is_point = (char_data == ASCII_POINT);
    cls.is_term  = (char_data == ASCII_SPACE) || (char_data == ASCII_LF) ||
                   (char_data == ASCII_CR)    || (char_data == ASCII_SEMI);
  end
endmodule

// File: rtl/ascii_fixed_point_parser.sv
// Purpose: parses ASCII decimal numbers into {sign, int, frac} sign-magnitude fixed point.
// Latency: result valid 1+(FRAC_DIGITS-fcnt) cycles after the terminator is accepted.
// Backpressure: char_ready low while padding or holding a result; result held until num_ready.
// Ports: clk, rst_n (async active-low), bus (slave: char stream in, num stream out).
module ascii_fixed_point_parser
  import ascii_fixed_point_parser_pkg::*;
#(
  parameter int INT_W       = INT_W_DEFAULT,
  parameter int FRAC_W      = FRAC_W_DEFAULT,
  parameter int FRAC_DIGITS = FRAC_DIGITS_DEFAULT
)(
  input  logic                  clk,
  input  logic                  rst_n,
  ascii_fixed_point_parser_if.slave bus
);
  localparam int NUM_W     = 1 + INT_W + FRAC_W;
  localparam int ACC_W     = INT_W + 4;
  localparam int FCNT_W    = $clog2(FRAC_DIGITS + 1);
  localparam logic [ACC_W-1:0]  INT_MAX  = ACC_W'((64'd1 << INT_W) - 64'd1);
  localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FRAC_DIGITS);

  state_t            state;
  logic [ACC_W-1:0]  int_acc;
  logic [FRAC_W-1:0] frac;
  logic [FCNT_W-1:0] fcnt;
  logic              neg;
  logic              has_digit;
  logic              ovf;
  logic [NUM_W-1:0]  num_data_q;
  logic              num_error_q;

  char_class_t       cls;
  logic              char_fire;
  logic [ACC_W-1:0]  int_next;
  logic [FRAC_W-1:0] frac_x10;
  logic [FRAC_W-1:0] frac_next;

  ascii_char_classify u_classify (
    .char_data (bus.char_data),
    .cls       (cls)
  );

  // Handshake outputs are decodes of the registered state, so they change only on edges.
  assign bus.char_ready = (state == ST_IDLE) || (state == ST_INT) ||
                          (state == ST_FRAC) || (state == ST_SKIP);
  assign bus.num_valid  = (state == ST_DONE);
  assign bus.num_data   = num_data_q;
  assign bus.num_error  = num_error_q;

  assign char_fire = bus.char_valid && bus.char_ready;

  // Multiply-by-10 as shift-and-add; the wide int accumulator leaves room to flag overflow.
  assign int_next  = (int_acc << 3) + (int_acc << 1) + ACC_W'(cls.digit);
  assign frac_x10  = (frac << 3) + (frac << 1);
  assign frac_next = frac_x10 + FRAC_W'(cls.digit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      int_acc     <= '0;
      frac        <= '0;
      fcnt        <= '0;
      neg         <= 1'b0;
      has_digit   <= 1'b0;
      ovf         <= 1'b0;
      num_data_q  <= '0;
      num_error_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (char_fire) begin
          if (cls.is_term) begin
            state <= ST_IDLE;
          end else if (cls.is_sign) begin
            neg   <= cls.is_neg;
            state <= ST_INT;
          end else if (cls.is_digit) begin
            int_acc   <= ACC_W'(cls.digit);
            has_digit <= 1'b1;
            state     <= ST_INT;
          end else if (cls.is_point) begin
            state <= ST_FRAC;
          end else begin
            state <= ST_SKIP;
          end
        end
        ST_INT: if (char_fire) begin
          if (cls.is_digit) begin
            has_digit <= 1'b1;
            // Once overflowed the accumulator is frozen; the result is an error anyway.
            if (!ovf) begin
              int_acc <= int_next;
              if (int_next > INT_MAX) ovf <= 1'b1;
            end
          end else if (cls.is_point) begin
            state <= ST_FRAC;
          end else if (cls.is_term) begin
            if (has_digit) begin
              state <= ST_PAD;
            end else begin
              state       <= ST_DONE;
              num_error_q <= 1'b1;
              num_data_q  <= '0;
            end
          end else begin
            state <= ST_SKIP;
          end
        end
        ST_FRAC: if (char_fire) begin
          if (cls.is_digit) begin
            has_digit <= 1'b1;
            // Digits beyond FRAC_DIGITS are dropped: truncation, no rounding.
            if (fcnt < FCNT_MAX) begin
              frac <= frac_next;
              fcnt <= fcnt + 1'b1;
            end
          end else if (cls.is_term) begin
            if (has_digit) begin
              state <= ST_PAD;
            end else begin
              state       <= ST_DONE;
              num_error_q <= 1'b1;
              num_data_q  <= '0;
            end
          end else begin
            state <= ST_SKIP;
          end
        end
        ST_SKIP: if (char_fire && cls.is_term) begin
          state       <= ST_DONE;
          num_error_q <= 1'b1;
          num_data_q  <= '0;
        end
        ST_PAD: begin
          // Scale the fraction up so it always represents FRAC_DIGITS decimal places.
          if (fcnt == FCNT_MAX) begin
            state <= ST_DONE;
            if (ovf) begin
              num_error_q <= 1'b1;
              num_data_q  <= '0;
            end else begin
              num_error_q <= 1'b0;
              // Negative zero is reported as +0.
              num_data_q  <= {neg && ((int_acc != '0) || (frac != '0)),
                              int_acc[INT_W-1:0], frac};
            end
          end else begin
            frac <= frac_x10;
            fcnt <= fcnt + 1'b1;
          end
        end
        ST_DONE: if (bus.num_ready) begin
          state       <= ST_IDLE;
          int_acc     <= '0;
          frac        <= '0;
          fcnt        <= '0;
          neg         <= 1'b0;
          has_digit   <= 1'b0;
          ovf         <= 1'b0;
          num_data_q  <= '0;
          num_error_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ascii_fixed_point_parser.sv
// Directed bench for ascii_fixed_point_parser: per-scenario tasks with inline checks.
module tb_ascii_fixed_point_parser;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ascii_fixed_point_parser_if bus ();

  ascii_fixed_point_parser dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] fx(input logic s, input int i, input int f);
    return {s, i[16:0], f[13:0]};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.char_valid = 1'b1;
    bus.char_data  = b;
    while (bus.char_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL send_timeout byte=%h char_ready=%b required=1", b, bus.char_ready);
    end
    @(posedge clk); #1;
    bus.char_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic get_result(input string name, input logic exp_err, input logic [31:0] exp_data);
    int n;
    n = 0;
    bus.num_ready = 1'b1;
    while (bus.num_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (bus.num_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_valid got=%b required=1", name, bus.num_valid);
    end
    checks++;
    if (bus.num_error !== exp_err) begin
      failures++;
      $display("FAIL %s_error got=%b required=%b", name, bus.num_error, exp_err);
    end
    checks++;
    if (bus.num_data !== exp_data) begin
      failures++;
      $display("FAIL %s_data got=%h required=%h", name, bus.num_data, exp_data);
    end
    @(posedge clk); #1;
    bus.num_ready = 1'b0;
    checks++;
    if (bus.num_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_release num_valid got=%b required=0", name, bus.num_valid);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.char_ready !== 1'b1 || bus.num_valid !== 1'b0 ||
        bus.num_data !== 32'h0 || bus.num_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b vld=%b dat=%h err=%b required 1 0 0 0",
               bus.char_ready, bus.num_valid, bus.num_data, bus.num_error);
    end
  endtask

  task automatic test_pad_latency();
    send_str("12.5");
    send_byte(8'h20);   // terminator accepted at the edge just passed (k)
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.num_valid !== 1'b0 || bus.char_ready !== 1'b0) begin
        failures++;
        $display("FAIL pad_cycle%0d vld=%b rdy=%b required 0 0", i, bus.num_valid, bus.char_ready);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bus.num_valid !== 1'b0) begin
      failures++;
      $display("FAIL pad_cycle3 vld=%b required=0", bus.num_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.num_valid !== 1'b1) begin
      failures++;
      $display("FAIL pad_latency vld=%b required=1 at k+4", bus.num_valid);
    end
    get_result("p12_5", 1'b0, fx(1'b0, 12, 5000));
  endtask

  task automatic test_sign_and_spaces();
    send_str("-0.0012\n"); get_result("neg_frac", 1'b0, fx(1'b1, 0, 12));
    send_str("-0\n");      get_result("neg_zero", 1'b0, fx(1'b0, 0, 0));
    send_str("  7;");      get_result("spaces7",  1'b0, fx(1'b0, 7, 0));
    send_str("+.5 ");      get_result("plus_pt5", 1'b0, fx(1'b0, 0, 5000));
  endtask

  task automatic test_truncate();
    send_str("3.14159;");
    checks++;
    if (bus.num_valid !== 1'b0) begin
      failures++;
      $display("FAIL trunc_latency_early vld=%b required=0", bus.num_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.num_valid !== 1'b1) begin
      failures++;
      $display("FAIL trunc_latency vld=%b required=1 at k+1", bus.num_valid);
    end
    get_result("pi", 1'b0, fx(1'b0, 3, 1415));
  endtask

  task automatic test_overflow();
    send_str("131071 "); get_result("int_max", 1'b0, fx(1'b0, 131071, 0));
    send_str("131072 "); get_result("int_ovf", 1'b1, 32'h0);
    send_str("-9999999.25 "); get_result("big_ovf", 1'b1, 32'h0);
  endtask

  task automatic test_malformed();
    send_str("1a2 "); get_result("illegal", 1'b1, 32'h0);
    send_str("-. ");  get_result("nodigit", 1'b1, 32'h0);
    send_str("1.2.3 "); get_result("twopt", 1'b1, 32'h0);
    send_str("5 ");   get_result("recover5", 1'b0, fx(1'b0, 5, 0));
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] exp;
    exp = fx(1'b0, 9, 9000);
    bus.num_ready = 1'b0;
    send_str("9.9 ");
    n = 0;
    while (bus.num_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    bus.char_valid = 1'b1;
    bus.char_data  = 8'h34;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.num_valid !== 1'b1 || bus.char_ready !== 1'b0 || bus.num_data !== exp) begin
        failures++;
        $display("FAIL bp_hold%0d vld=%b rdy=%b dat=%h required 1 0 %h",
                 i, bus.num_valid, bus.char_ready, bus.num_data, exp);
      end
      @(posedge clk); #1;
    end
    get_result("bp_release", 1'b0, exp);
    send_byte(8'h34);
    send_byte(8'h20);
    get_result("bp_next4", 1'b0, fx(1'b0, 4, 0));
  endtask

  task automatic test_reset_mid();
    send_str("12.3");
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.char_ready !== 1'b1 || bus.num_valid !== 1'b0 ||
        bus.num_data !== 32'h0 || bus.num_error !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got rdy=%b vld=%b dat=%h err=%b required 1 0 0 0",
               bus.char_ready, bus.num_valid, bus.num_data, bus.num_error);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.num_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_stale vld=%b required=0", bus.num_valid);
    end
    send_str("8 ");
    get_result("after_reset8", 1'b0, fx(1'b0, 8, 0));
  endtask

  initial begin
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    bus.num_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_pad_latency();
    test_sign_and_spaces();
    test_truncate();
    test_overflow();
    test_malformed();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ascii_fixed_point_parser.md
Name: ascii_fixed_point_parser

Overview:
- Converts a byte stream of ASCII decimal numbers, as found in G-code words, into the sign-magnitude fixed-point format consumed by the fixed-point ALU: {sign, integer part, decimal fraction part}.
- The fraction part holds the value of the first FRAC_DIGITS decimal digits (0..10^FRAC_DIGITS-1).
- Sits between the G-code tokenizer and the ALU / motion-planner input registers.
- Valid/ready handshake on both sides.

Parameters:
- INT_W, 17: integer-part width (unsigned magnitude).
- FRAC_W, 14: fraction-part width.
- FRAC_DIGITS, 4: decimal digits kept in the fraction; max fraction 9999.
- NUM_W, 1+INT_W+FRAC_W (32): packed result width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- char_valid  in  1  char_data is valid.
- char_data  in  8  ASCII byte.
- char_ready  out  1  parser accepts a byte this cycle.
- num_valid  out  1  result valid.
- num_data  out  NUM_W  {sign, int[INT_W-1:0], frac[FRAC_W-1:0]}.
- num_error  out  1  qualifies num_valid: malformed or overflowed number; num_data=0.
- num_ready  in  1  consumer takes the result.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset state: IDLE. Accumulators cleared. num_valid=0, num_data=0, num_error=0, char_ready=1.
- Byte transfer: char_valid && char_ready at a rising edge. Result transfer: num_valid && num_ready.
- Byte classes:
  - digit: 0x30-0x39.
  - sign: '+' or '-'.
  - point: '.'.
  - terminator: 0x20, 0x0A, 0x0D, ';'.
  - anything else: illegal.
- IDLE:
  - terminator: ignored (whitespace skipping).
  - sign: set neg flag, go to INT.
  - digit: int=digit, go to INT.
  - point: go to FRAC.
  - illegal: go to SKIP.
- INT:
  - digit: int = int*10 + digit. If the result exceeds 2^INT_W-1, set ovf.
  - point: go to FRAC.
  - terminator: go to PAD or DONE (see below).
  - sign or illegal: go to SKIP.
- FRAC:
  - digit: if fcnt < FRAC_DIGITS, frac = frac*10 + digit and fcnt++; otherwise the digit is consumed and discarded (truncation, no rounding).
  - terminator: go to PAD or DONE.
  - point, sign or illegal: go to SKIP.
- SKIP: consumes bytes until a terminator, then goes to DONE with error.
- No-digit rule: a number with no digit at all (e.g. "-", ".", "-.") ends in DONE with error.
- PAD:
  - char_ready=0.
  - Each cycle frac = frac*10 and fcnt++, until fcnt == FRAC_DIGITS, then go to DONE.
  - Latency: terminator accepted at edge k → num_valid=1 after edge k+1+(FRAC_DIGITS-fcnt).
- DONE:
  - char_ready=0, num_valid=1. num_data/num_error held stable until num_ready.
  - On the result transfer: clear accumulators, return to IDLE. char_ready=1 from the next cycle.
- Normalisation: if int==0 and frac==0, sign=0 (negative zero becomes +0).
- Error result: num_error=1 and num_data=0 on ovf or a SKIP path.
- Width rules:
  - int accumulator is INT_W+4 bits so overflow can be detected; ovf is sticky.
  - frac never exceeds 10^FRAC_DIGITS-1.
- char_data is ignored while char_ready=0. No byte is lost under back-pressure.
- Reset asserted mid-number or mid-DONE: immediate return to reset state. A partial number is discarded and no result is emitted.

Decomposition:
- Shared include (configuration header): INT_W/FRAC_W/FRAC_DIGITS defaults, FLOAT_NUMBER_MAX_FLOAT_PART (9999), ASCII class constants, state encodings.
- Sub-module ascii_char_classify (combinational): byte → {is_digit, digit[3:0], is_sign, is_neg, is_point, is_term}.
- The multiply-by-10 is (x<<3)+(x<<1), inline.

Test Plan:
- "12.5 " then num_ready=1 → 3 PAD cycles; num_valid one cycle later with sign=0, int=12, frac=5000, error=0.
- "-0.0012\n" → sign=1, int=0, frac=12. "-0\n" → sign=0, int=0, frac=0 (normalised). "  7;" → leading spaces skipped, int=7, frac=0.
- "3.14159;" → int=3, frac=1415 (fifth digit dropped). "131071 " → int=131071, no error. "131072 " → num_error=1, num_data=0.
- "1a2 " and "-. " → num_error=1, num_data=0. The next number "5 " parses cleanly to int=5.
- Back-pressure: hold num_ready=0 for 10 cycles after "9.9 " → num_data stable, char_ready=0, queued bytes of "4 " are not consumed. On release: 9.9000 transfers, then 4 is parsed correctly.
- Pulse rst_n low after "12.3" (before terminator) → outputs reset immediately. Following "8 " yields int=8 only; no stale result is emitted.
